// File: rtl/nes_controller_responder.sv
// rtl/nes_controller_responder.sv - NES joypad (4021-style) serial responder on the latch/clk/data host interface
module nes_controller_responder #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TO_W           = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] buttons,
    input  logic       nes_latch,
    input  logic       nes_clk,
    output logic       nes_data,
    output logic       frame_done,
    output logic       timeout,
    output logic [7:0] poll_count
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DRAIN} state_t;

    // The last idle cycle is detected one count early so TIMEOUT_CYCLES = 2^TO_W still fits.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

    logic [SYNC_STAGES-1:0] latch_sync_q;
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic                   latch_prev_q;
    logic                   clk_prev_q;

    state_t          state_q;
    logic [7:0]      shreg_q;
    logic [2:0]      bit_cnt_q;
    logic [TO_W-1:0] to_cnt_q;
    logic            data_q;
    logic            frame_done_q;
    logic            timeout_q;
    logic [7:0]      poll_q;

    logic latch_s;
    logic clk_s;
    logic latch_rise;
    logic latch_fall;
    logic clk_rise;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            latch_sync_q <= '0;
            clk_sync_q   <= '0;
            latch_prev_q <= 1'b0;
            clk_prev_q   <= 1'b0;
        end else begin
            latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], nes_latch};
            clk_sync_q   <= {clk_sync_q[SYNC_STAGES-2:0], nes_clk};
            latch_prev_q <= latch_sync_q[SYNC_STAGES-1];
            clk_prev_q   <= clk_sync_q[SYNC_STAGES-1];
        end
    end

    assign latch_s    = latch_sync_q[SYNC_STAGES-1];
    assign clk_s      = clk_sync_q[SYNC_STAGES-1];
    assign latch_rise = latch_s & ~latch_prev_q;
    assign latch_fall = ~latch_s & latch_prev_q;
    assign clk_rise   = clk_s & ~clk_prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shreg_q      <= 8'hFF;
            bit_cnt_q    <= 3'd0;
            to_cnt_q     <= '0;
            data_q       <= 1'b1;
            frame_done_q <= 1'b0;
            timeout_q    <= 1'b0;
            poll_q       <= 8'd0;
        end else begin
            frame_done_q <= 1'b0;
            timeout_q    <= 1'b0;
            // A new latch always wins, aborting any partial frame and masking a coincident clock edge.
            if (latch_rise) begin
                state_q  <= LOAD;
                shreg_q  <= ~buttons;
                data_q   <= ~buttons[0];
                to_cnt_q <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        data_q <= 1'b1;
                        if (latch_s) begin
                            state_q <= LOAD;
                            shreg_q <= ~buttons;
                            data_q  <= ~buttons[0];
                        end
                    end
                    LOAD: begin
                        if (latch_fall) begin
                            state_q   <= SHIFT;
                            bit_cnt_q <= 3'd0;
                            to_cnt_q  <= '0;
                        end else begin
                            shreg_q <= ~buttons;
                            data_q  <= ~buttons[0];
                        end
                    end
                    SHIFT, DRAIN: begin
                        if (clk_rise) begin
                            shreg_q  <= {1'b0, shreg_q[7:1]};
                            data_q   <= shreg_q[1];
                            to_cnt_q <= '0;
                            if (state_q == SHIFT) begin
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                                // Bit 7 now exposed: the frame is complete.
                                if (bit_cnt_q == 3'd6) begin
                                    frame_done_q <= 1'b1;
                                    poll_q       <= poll_q + 8'd1;
                                    state_q      <= DRAIN;
                                end
                            end
                        end else if (to_cnt_q == TO_LAST) begin
                            timeout_q <= 1'b1;
                            state_q   <= IDLE;
                            data_q    <= 1'b1;
                            to_cnt_q  <= '0;
                        end else begin
                            to_cnt_q <= to_cnt_q + TO_ONE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign nes_data   = data_q;
    assign frame_done = frame_done_q;
    assign timeout    = timeout_q;
    assign poll_count = poll_q;

endmodule

// File: tb/tb_nes_controller_responder.sv
// tb/tb_nes_controller_responder.sv - randomized self-checking bench for nes_controller_responder
`timescale 1ns/1ps
module tb_nes_controller_responder;

    logic       clk;
    logic       rst_n;
    logic [7:0] buttons;
    logic       nes_latch;
    logic       nes_clk;
    logic       nes_data;
    logic       frame_done;
    logic       timeout;
    logic [7:0] poll_count;

    int n_checks;
    int n_fail;
    int fd_cnt;
    int to_pulses;
    int exp_poll;

    nes_controller_responder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .buttons    (buttons),
        .nes_latch  (nes_latch),
        .nes_clk    (nes_clk),
        .nes_data   (nes_data),
        .frame_done (frame_done),
        .timeout    (timeout),
        .poll_count (poll_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_cnt++;
        if (timeout === 1'b1) to_pulses++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Host side: n rising clock edges, sampling nes_data just before each edge.
    task automatic shift_out(input int hp, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx[i] = nes_data;
            @(posedge clk);
            #1 nes_clk = 1'b1;
            wait_cyc(hp);
            nes_clk = 1'b0;
            wait_cyc(hp);
        end
    endtask

    task automatic host_frame(input logic [7:0] b, input bit sim, input int hp, output logic [7:0] rx);
        buttons   = b;
        nes_latch = 1'b1;
        wait_cyc(hp);
        nes_latch = 1'b0;
        if (sim) begin
            nes_clk = 1'b1;
            wait_cyc(hp);
            nes_clk = 1'b0;
        end
        wait_cyc(hp);
        shift_out(hp, 8, rx);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        wait_cyc(3);
        @(negedge clk);
        n_checks++;
        if ({nes_data, frame_done, timeout, poll_count} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_values: got data=%b fd=%b to=%b poll=%0d expected 1 0 0 0",
                     nes_data, frame_done, timeout, poll_count);
        end
        rst_n = 1'b1;
        exp_poll = 0;
        fd_cnt = 0;
        to_pulses = 0;
        wait_cyc(50);
        @(negedge clk);
        n_checks++;
        if (nes_data !== 1'b1 || poll_count !== 8'd0 || fd_cnt != 0) begin
            n_fail++;
            $display("FAIL idle_quiet: got data=%b poll=%0d fd=%0d expected 1 0 0", nes_data, poll_count, fd_cnt);
        end
    endtask

    task automatic test_basic;
        logic [7:0] rx;
        int fd0;
        fd0 = fd_cnt;
        host_frame(8'b0000_0101, 1'b0, 12, rx);
        exp_poll = (exp_poll + 1) % 256;
        n_checks++;
        if (rx !== 8'b1111_1010) begin
            n_fail++;
            $display("FAIL basic_bits: got %b expected %b (bit0 first)", rx, 8'b1111_1010);
        end
        @(negedge clk);
        n_checks++;
        if (nes_data !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_drain: got nes_data=%b expected 0", nes_data);
        end
        n_checks++;
        if (fd_cnt - fd0 != 1 || poll_count !== 8'(exp_poll)) begin
            n_fail++;
            $display("FAIL basic_count: got fd=%0d poll=%0d expected 1 %0d", fd_cnt - fd0, poll_count, exp_poll);
        end
    endtask

    task automatic test_random_frames;
        logic [7:0] b;
        logic [7:0] rx;
        for (int k = 0; k < 6; k++) begin
            b = 8'($urandom);
            host_frame(b, (k % 2) == 1, 3 + (k % 3) * 4, rx);
            exp_poll = (exp_poll + 1) % 256;
            n_checks++;
            if (rx !== ~b) begin
                n_fail++;
                $display("FAIL rand_frame%0d: got %b expected %b sim=%0d", k, rx, ~b, k % 2);
            end
        end
        n_checks++;
        if (poll_count !== 8'(exp_poll)) begin
            n_fail++;
            $display("FAIL rand_poll: got %0d expected %0d", poll_count, exp_poll);
        end
    endtask

    task automatic test_buttons_during_latch;
        logic [7:0] rx;
        buttons   = 8'hFF;
        nes_latch = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_cyc(3);
            buttons = (i % 2 == 0) ? 8'h00 : 8'hFF;
        end
        buttons = 8'h00;
        wait_cyc(20);
        nes_latch = 1'b0;
        wait_cyc(12);
        buttons = 8'($urandom);
        shift_out(12, 8, rx);
        exp_poll = (exp_poll + 1) % 256;
        n_checks++;
        if (rx !== 8'hFF) begin
            n_fail++;
            $display("FAIL latch_toggle: got %b expected 11111111", rx);
        end
    endtask

    task automatic test_timeout;
        logic [7:0] rx;
        int fd0;
        int to0;
        int first;
        buttons = 8'($urandom);
        fd0 = fd_cnt;
        to0 = to_pulses;
        nes_latch = 1'b1;
        wait_cyc(12);
        nes_latch = 1'b0;
        wait_cyc(12);
        shift_out(12, 2, rx);
        @(posedge clk);
        #1 nes_clk = 1'b1;
        first = -1;
        for (int c = 1; c <= 5000; c++) begin
            @(negedge clk);
            if (timeout === 1'b1 && first < 0) first = c;
        end
        n_checks++;
        if (first < 4096 || first > 4110) begin
            n_fail++;
            $display("FAIL timeout_time: got pulse at cycle %0d expected about 4096 after last edge", first);
        end
        n_checks++;
        if (to_pulses - to0 != 1 || nes_data !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_pulse: got pulses=%0d data=%b expected 1 1", to_pulses - to0, nes_data);
        end
        n_checks++;
        if (poll_count !== 8'(exp_poll) || fd_cnt != fd0) begin
            n_fail++;
            $display("FAIL timeout_poll: got poll=%0d fd=%0d expected %0d 0", poll_count, fd_cnt - fd0, exp_poll);
        end
        nes_clk = 1'b0;
        wait_cyc(12);
    endtask

    task automatic test_abort;
        logic [7:0] rx;
        logic [7:0] b;
        int fd0;
        fd0 = fd_cnt;
        buttons = 8'($urandom);
        nes_latch = 1'b1;
        wait_cyc(12);
        nes_latch = 1'b0;
        wait_cyc(12);
        shift_out(12, 4, rx);
        b = 8'($urandom);
        host_frame(b, 1'b0, 12, rx);
        exp_poll = (exp_poll + 1) % 256;
        n_checks++;
        if (rx !== ~b || fd_cnt - fd0 != 1) begin
            n_fail++;
            $display("FAIL abort_frame: got rx=%b fd=%0d expected %b 1", rx, fd_cnt - fd0, ~b);
        end
        n_checks++;
        if (poll_count !== 8'(exp_poll)) begin
            n_fail++;
            $display("FAIL abort_poll: got %0d expected %0d", poll_count, exp_poll);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] rx;
        logic [7:0] b;
        buttons = 8'($urandom);
        nes_latch = 1'b1;
        wait_cyc(12);
        nes_latch = 1'b0;
        wait_cyc(12);
        shift_out(12, 3, rx);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_poll = 0;
        @(negedge clk);
        n_checks++;
        if ({nes_data, frame_done, timeout, poll_count} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_mid: got data=%b fd=%b to=%b poll=%0d expected 1 0 0 0",
                     nes_data, frame_done, timeout, poll_count);
        end
        wait_cyc(12);
        b = 8'($urandom);
        host_frame(b, 1'b0, 12, rx);
        exp_poll = (exp_poll + 1) % 256;
        n_checks++;
        if (rx !== ~b || poll_count !== 8'd1) begin
            n_fail++;
            $display("FAIL reset_mid_frame: got rx=%b poll=%0d expected %b 1", rx, poll_count, ~b);
        end
    endtask

    task automatic test_wrap;
        logic [7:0] rx;
        logic [7:0] b;
        int fd0;
        int bad;
        rst_n = 1'b0;
        wait_cyc(1);
        rst_n = 1'b1;
        exp_poll = 0;
        wait_cyc(5);
        fd0 = fd_cnt;
        bad = 0;
        for (int k = 0; k < 256; k++) begin
            b = 8'($urandom);
            host_frame(b, 1'b0, 4, rx);
            exp_poll = (exp_poll + 1) % 256;
            if (rx !== ~b) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL wrap_data: got %0d bad frames expected 0", bad);
        end
        @(negedge clk);
        n_checks++;
        if (poll_count !== 8'(exp_poll) || fd_cnt - fd0 != 256) begin
            n_fail++;
            $display("FAIL wrap_count: got poll=%0d fd=%0d expected %0d 256", poll_count, fd_cnt - fd0, exp_poll);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        fd_cnt    = 0;
        to_pulses = 0;
        exp_poll  = 0;
        rst_n     = 1'b0;
        buttons   = 8'h00;
        nes_latch = 1'b0;
        nes_clk   = 1'b0;
        test_reset;
        test_basic;
        test_random_frames;
        test_buttons_during_latch;
        test_timeout;
        test_abort;
        test_reset_mid;
        test_wrap;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
